// File: rtl/mips_pkg.sv
// Shared types and constants for the register-file write-back path.
package mips_pkg;

    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;
    localparam int NUM_WB_PORTS = 2;
    localparam int REG_ZERO     = 0;

    // Bit positions of each requester in request/grant vectors
    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer hands priority to the loser after every grant.
module rr_arbiter2
    import mips_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_WB_PORTS-1:0] i_req,
    output logic [NUM_WB_PORTS-1:0] o_grant,
    output logic                    o_prio_b
);

    logic                    r_prio_b;
    logic [NUM_WB_PORTS-1:0] w_grant;

    always_comb begin
        w_grant = '0;
        if (i_req[PORT_A] && (!i_req[PORT_B] || !r_prio_b)) begin
            w_grant[PORT_A] = 1'b1;
        end else if (i_req[PORT_B]) begin
            w_grant[PORT_B] = 1'b1;
        end
    end

    // Granting A moves priority to B and vice versa; idle cycles leave it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_b <= 1'b0;
        end else if (|w_grant) begin
            r_prio_b <= w_grant[PORT_A];
        end
    end

    assign o_grant  = w_grant;
    assign o_prio_b = r_prio_b;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU (A) and load (B) write-back paths.
// Define WB_FORWARD_EN to add the write-to-read bypass ports and mux.
module regfile_write_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ValidA,
    input  logic [ADDR_W-1:0] RegA,
    input  logic [DATA_W-1:0] DataA,
    output logic              ReadyA,
    input  logic              ValidB,
    input  logic [ADDR_W-1:0] RegB,
    input  logic [DATA_W-1:0] DataB,
    output logic              ReadyB,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWriteActive,
    output logic [CNT_W-1:0]  ConflictCntA,
    output logic [CNT_W-1:0]  ConflictCntB
`ifdef WB_FORWARD_EN
    ,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic [DATA_W-1:0] RfData1,
    input  logic [DATA_W-1:0] RfData2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
`endif
);

    logic [NUM_WB_PORTS-1:0] w_valid;
    logic [NUM_WB_PORTS-1:0] w_grant;
    logic                    w_prio_b;
    logic                    w_any_grant;
    logic [ADDR_W-1:0]       w_sel_reg;
    logic [DATA_W-1:0]       w_sel_data;

    logic                    r_we;
    logic [ADDR_W-1:0]       r_wreg;
    logic [DATA_W-1:0]       r_wdata;
    logic [CNT_W-1:0]        r_conflict_cnt [NUM_WB_PORTS];

    assign w_valid[PORT_A] = ValidA;
    assign w_valid[PORT_B] = ValidB;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (w_valid),
        .o_grant  (w_grant),
        .o_prio_b (w_prio_b)
    );

    assign ReadyA      = w_grant[PORT_A];
    assign ReadyB      = w_grant[PORT_B];
    assign w_any_grant = |w_grant;
    assign w_sel_reg   = w_grant[PORT_B] ? RegB  : RegA;
    assign w_sel_data  = w_grant[PORT_B] ? DataB : DataA;

    // Register-0 writes are accepted but never enable the write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_any_grant && (w_sel_reg != ADDR_W'(REG_ZERO));
            if (w_any_grant) begin
                r_wreg  <= w_sel_reg;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign RegWriteActive = r_we;
    assign WriteReg       = r_wreg;
    assign WriteData      = r_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WB_PORTS; gi++) begin : g_conflict
            // Saturating count of cycles this port waited on the other
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_conflict_cnt[gi] <= '0;
                end else if (w_valid[gi] && !w_grant[gi] &&
                             (r_conflict_cnt[gi] != {CNT_W{1'b1}})) begin
                    r_conflict_cnt[gi] <= r_conflict_cnt[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign ConflictCntA = r_conflict_cnt[PORT_A];
    assign ConflictCntB = r_conflict_cnt[PORT_B];

`ifdef WB_FORWARD_EN
    logic [ADDR_W-1:0] w_rd_idx  [2];
    logic [DATA_W-1:0] w_rf_data [2];
    logic [DATA_W-1:0] w_fwd     [2];

    assign w_rd_idx[0]  = ReadRegister1;
    assign w_rd_idx[1]  = ReadRegister2;
    assign w_rf_data[0] = RfData1;
    assign w_rf_data[1] = RfData2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_fwd[gi] = (r_we && (r_wreg == w_rd_idx[gi])) ? r_wdata : w_rf_data[gi];
        end
    endgenerate

    assign ReadData1 = w_fwd[0];
    assign ReadData2 = w_fwd[1];
`endif

    logic w_unused;
    assign w_unused = w_prio_b;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter; expected writes are queued as grants are driven.
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          clk;
    logic          rst_n;
    logic          ValidA, ValidB;
    logic [AW-1:0] RegA, RegB;
    logic [DW-1:0] DataA, DataB;
    logic          ReadyA, ReadyB;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic          RegWriteActive;
    logic [CW-1:0] ConflictCntA, ConflictCntB;
`ifdef WB_FORWARD_EN
    logic [AW-1:0] ReadRegister1, ReadRegister2;
    logic [DW-1:0] RfData1, RfData2, ReadData1, ReadData2;
`endif

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ValidA         (ValidA),
        .RegA           (RegA),
        .DataA          (DataA),
        .ReadyA         (ReadyA),
        .ValidB         (ValidB),
        .RegB           (RegB),
        .DataB          (DataB),
        .ReadyB         (ReadyB),
        .WriteReg       (WriteReg),
        .WriteData      (WriteData),
        .RegWriteActive (RegWriteActive),
        .ConflictCntA   (ConflictCntA),
        .ConflictCntB   (ConflictCntB)
`ifdef WB_FORWARD_EN
        ,
        .ReadRegister1  (ReadRegister1),
        .ReadRegister2  (ReadRegister2),
        .RfData1        (RfData1),
        .RfData2        (RfData2),
        .ReadData1      (ReadData1),
        .ReadData2      (ReadData2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          act;
        logic          chk;
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic          m_prio;
    logic [CW-1:0] m_cnt_a, m_cnt_b;
    logic [AW-1:0] m_reg;
    logic [DW-1:0] m_data;
    logic [DW-1:0] shadow [32];

    always @(posedge clk) begin
        if (RegWriteActive) shadow[WriteReg] <= WriteData;
    end

    task automatic model_reset();
        sb.delete();
        m_prio = 1'b0; m_cnt_a = '0; m_cnt_b = '0; m_reg = '0; m_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ValidA = 1'b0; ValidB = 1'b0; RegA = '0; RegB = '0; DataA = '0; DataB = '0;
`ifdef WB_FORWARD_EN
        ReadRegister1 = '0; ReadRegister2 = '0; RfData1 = '0; RfData2 = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Predict this cycle's grant from the spec's round-robin rule, queue the write, advance one clock
    task automatic tick();
        exp_t e;
        logic ga, gb;
        ga = ValidA && (!ValidB || !m_prio);
        gb = ValidB && !ga;
        e.act = (ga && RegA != 0) || (gb && RegB != 0);
        e.chk = ga ? (RegA != 0) : (gb ? (RegB != 0) : 1'b1);
        if (ga) begin m_reg = RegA; m_data = DataA; end
        else if (gb) begin m_reg = RegB; m_data = DataB; end
        e.r = m_reg;
        e.d = m_data;
        if (ga || gb) m_prio = ga;
        if (ValidA && !ga && m_cnt_a != CNT_MAX) m_cnt_a = m_cnt_a + 1'b1;
        if (ValidB && !gb && m_cnt_b != CNT_MAX) m_cnt_b = m_cnt_b + 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({RegWriteActive, WriteReg, WriteData} !== '0) begin
            errors++;
            $display("FAIL reset_wport: got act=%0b reg=%0d data=%h, want all 0", RegWriteActive, WriteReg, WriteData);
        end
        checks++;
        if (ConflictCntA !== '0 || ConflictCntB !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got A=%0d B=%0d, want 0 0", ConflictCntA, ConflictCntB);
        end
        checks++;
        if (ReadyA !== 1'b0 || ReadyB !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got A=%0b B=%0b, want 0 0", ReadyA, ReadyB);
        end
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        ValidA = 1'b1; RegA = 5'd5; DataA = 32'h1234;
        #1;
        checks++;
        if (ReadyA !== 1'b1 || ReadyB !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got A=%0b B=%0b, want 1 0", ReadyA, ReadyB);
        end
        tick();
        ValidA = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) tick();
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL single_sb: scoreboard empty, want 1 entry");
            end else begin
                e = sb.pop_front();
                $display("single: act=%0b reg=%0d data=%h", RegWriteActive, WriteReg, WriteData);
                if (RegWriteActive !== e.act || (e.chk && (WriteReg !== e.r || WriteData !== e.d))) begin
                    errors++;
                    $display("FAIL single_write: got act=%0b reg=%0d data=%h, want act=%0b reg=%0d data=%h",
                             RegWriteActive, WriteReg, WriteData, e.act, e.r, e.d);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ValidA = 1'b1; RegA = AW'(i + 1); DataA = $urandom;
            tick();
            checks++;
            e = sb.pop_front();
            $display("b2b: act=%0b reg=%0d data=%h", RegWriteActive, WriteReg, WriteData);
            if (RegWriteActive !== 1'b1 || WriteReg !== e.r || WriteData !== e.d) begin
                errors++;
                $display("FAIL b2b_write: got act=%0b reg=%0d data=%h, want act=1 reg=%0d data=%h",
                         RegWriteActive, WriteReg, WriteData, e.r, e.d);
            end
        end
        ValidA = 1'b0;
    endtask

    task automatic test_contention();
        exp_t e;
        do_reset();
        ValidA = 1'b1; RegA = 5'd3; DataA = 32'hA0A0;
        ValidB = 1'b1; RegB = 5'd4; DataB = 32'hB0B0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ReadyA !== (i % 2 == 0) || ReadyB !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL contention_ready%0d: got A=%0b B=%0b, want A=%0b B=%0b",
                         i, ReadyA, ReadyB, (i % 2 == 0), (i % 2 == 1));
            end
            tick();
            checks++;
            e = sb.pop_front();
            $display("contention: act=%0b reg=%0d data=%h", RegWriteActive, WriteReg, WriteData);
            if (RegWriteActive !== e.act || WriteReg !== e.r || WriteData !== e.d ||
                WriteReg !== ((i % 2 == 0) ? 5'd3 : 5'd4)) begin
                errors++;
                $display("FAIL contention_write%0d: got act=%0b reg=%0d data=%h, want act=%0b reg=%0d data=%h",
                         i, RegWriteActive, WriteReg, WriteData, e.act, e.r, e.d);
            end
        end
        ValidA = 1'b0; ValidB = 1'b0;
        checks++;
        if (ConflictCntA !== 4'd2 || ConflictCntB !== 4'd2 || ConflictCntA !== m_cnt_a) begin
            errors++;
            $display("FAIL contention_cnt: got A=%0d B=%0d, want 2 2", ConflictCntA, ConflictCntB);
        end
    endtask

    task automatic test_same_reg();
        exp_t e;
        do_reset();
        ValidA = 1'b1; RegA = 5'd7; DataA = 32'hAA;
        ValidB = 1'b1; RegB = 5'd7; DataB = 32'hBB;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) ValidA = 1'b0;
            if (i == 1) ValidB = 1'b0;
            checks++;
            e = sb.pop_front();
            $display("same_reg: act=%0b reg=%0d data=%h", RegWriteActive, WriteReg, WriteData);
            if (RegWriteActive !== e.act || WriteReg !== e.r || WriteData !== e.d) begin
                errors++;
                $display("FAIL same_reg_write%0d: got act=%0b reg=%0d data=%h, want act=%0b reg=%0d data=%h",
                         i, RegWriteActive, WriteReg, WriteData, e.act, e.r, e.d);
            end
        end
        checks++;
        if (shadow[7] !== 32'hBB) begin
            errors++;
            $display("FAIL same_reg_final: got %h, want 000000bb", shadow[7]);
        end
    endtask

    task automatic test_reg0();
        exp_t e;
        do_reset();
        ValidB = 1'b1; RegB = 5'd0; DataB = 32'hDEAD;
        #1;
        checks++;
        if (ReadyB !== 1'b1) begin
            errors++;
            $display("FAIL reg0_ready: got %0b, want 1", ReadyB);
        end
        tick();
        ValidB = 1'b0;
        e = sb.pop_front();
        checks++;
        $display("reg0: act=%0b reg=%0d data=%h", RegWriteActive, WriteReg, WriteData);
        if (RegWriteActive !== e.act || RegWriteActive !== 1'b0) begin
            errors++;
            $display("FAIL reg0_write: got act=%0b, want 0", RegWriteActive);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        do_reset();
        ValidA = 1'b1; RegA = 5'd12; ValidB = 1'b1; RegB = 5'd13;
        for (int i = 0; i < 40; i++) begin
            DataA = $urandom; DataB = $urandom;
            tick();
            e = sb.pop_front();
            checks++;
            if (RegWriteActive !== e.act || WriteReg !== e.r || WriteData !== e.d) begin
                errors++;
                $display("FAIL sat_write%0d: got act=%0b reg=%0d data=%h, want act=%0b reg=%0d data=%h",
                         i, RegWriteActive, WriteReg, WriteData, e.act, e.r, e.d);
            end
        end
        ValidA = 1'b0; ValidB = 1'b0;
        checks++;
        if (ConflictCntA !== CNT_MAX || ConflictCntB !== CNT_MAX) begin
            errors++;
            $display("FAIL sat_cnt: got A=%0d B=%0d, want %0d %0d", ConflictCntA, ConflictCntB, CNT_MAX, CNT_MAX);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        ValidA = 1'b1; RegA = 5'd10; DataA = 32'h1010;
        ValidB = 1'b1; RegB = 5'd11; DataB = 32'h1111;
        repeat (3) begin
            tick();
            e = sb.pop_front();
        end
        checks++;
        if (RegWriteActive !== 1'b1 || ConflictCntB === '0) begin
            errors++;
            $display("FAIL rstmid_pre: got act=%0b cntB=%0d, want act=1 cntB>0", RegWriteActive, ConflictCntB);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({RegWriteActive, WriteReg, WriteData} !== '0 || ConflictCntA !== '0 || ConflictCntB !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: got act=%0b reg=%0d data=%h cntA=%0d cntB=%0d, want all 0",
                     RegWriteActive, WriteReg, WriteData, ConflictCntA, ConflictCntB);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ReadyA !== 1'b1 || ReadyB !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_prio: got A=%0b B=%0b, want 1 0", ReadyA, ReadyB);
        end
        tick();
        ValidA = 1'b0; ValidB = 1'b0;
        e = sb.pop_front();
        checks++;
        $display("rstmid: act=%0b reg=%0d data=%h", RegWriteActive, WriteReg, WriteData);
        if (RegWriteActive !== e.act || WriteReg !== 5'd10 || WriteData !== e.d) begin
            errors++;
            $display("FAIL rstmid_write: got act=%0b reg=%0d data=%h, want act=1 reg=10 data=%h",
                     RegWriteActive, WriteReg, WriteData, e.d);
        end
    endtask

`ifdef WB_FORWARD_EN
    task automatic test_forward();
        exp_t e;
        do_reset();
        ValidA = 1'b1; RegA = 5'd9; DataA = 32'h55;
        tick();
        ValidA = 1'b0;
        e = sb.pop_front();
        ReadRegister1 = 5'd9; RfData1 = 32'h11;
        ReadRegister2 = 5'd8; RfData2 = 32'h22;
        #1;
        checks++;
        if (ReadData1 !== 32'h55 || ReadData2 !== 32'h22 || WriteData !== e.d) begin
            errors++;
            $display("FAIL fwd_hit: got rd1=%h rd2=%h, want 00000055 00000022", ReadData1, ReadData2);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if (ReadData1 !== 32'h11 || RegWriteActive !== e.act) begin
            errors++;
            $display("FAIL fwd_idle: got rd1=%h act=%0b, want 00000011 0", ReadData1, RegWriteActive);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_contention();
        test_same_reg();
        test_reg0();
        test_saturation();
        test_reset_mid();
`ifdef WB_FORWARD_EN
        test_forward();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between two write-back requesters: the ALU result path (port A) and the load/memory result path (port B). Each requester uses a valid/ready handshake. Writes are granted round-robin and presented to the register file through a registered write port. An optional bypass returns in-flight write data to the read ports.

## Interface

Parameters:
- `DATA_W`, 32, write-data width
- `ADDR_W`, 5, register index width (32 registers)
- `CNT_W`, 16, width of the saturating conflict counters

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `ValidA`  in  1  ALU write-back request
- `RegA`  in  ADDR_W  ALU destination register
- `DataA`  in  DATA_W  ALU result
- `ReadyA`  out  1  ALU request accepted this cycle
- `ValidB`, `RegB`, `DataB`, `ReadyB`  same as above, for the load path
- `WriteReg`  out  ADDR_W  register-file write index
- `WriteData`  out  DATA_W  register-file write data
- `RegWriteActive`  out  1  register-file write enable
- `ConflictCntA`, `ConflictCntB`  out  CNT_W  cycles in which that port was valid but not granted
- `ReadRegister1`, `ReadRegister2`  in  ADDR_W  register-file read indices (WB_FORWARD_EN only)
- `RfData1`, `RfData2`  in  DATA_W  raw register-file read data (WB_FORWARD_EN only)
- `ReadData1`, `ReadData2`  out  DATA_W  forwarded read data (WB_FORWARD_EN only)

## Operation

- **Handshake.** A transfer occurs in any cycle where both Valid and Ready are high.
  - Ready is combinational from the Valid inputs and the priority pointer.
  - Requesters hold Reg and Data stable while Valid is high and Ready is low.
- **Arbitration.**
  - Only one valid port: that port is granted.
  - Both ports valid: the port indicated by the 1-bit pointer `PrioB` is granted (0 = A, 1 = B).
  - After any grant, `PrioB` points to the port that was not granted.
  - Only one Ready is ever high in a cycle.
- **Pointer.** Reset value is 0, so A has priority first. The pointer updates only on a grant.
- **Same destination register.** Both ports may target the same register. They are not merged; the loser waits and writes in a later cycle, so the later grant's data wins.
- **Register 0.** A write to register 0 is accepted (Ready high) but produces `RegWriteActive`=0 on the write port.
- **Conflict counters.**
  - A counter increments when its port has Valid=1 and Ready=0.
  - Each counter saturates at all ones and never wraps.
  - Counters are cleared only by reset.
- **Reset mid-operation.** Asserting `rst_n` low immediately clears:
  - the output register (`RegWriteActive`=0, `WriteReg`=0, `WriteData`=0),
  - `PrioB`=0,
  - both counters.
  An in-flight write is dropped.

## Timing

- **Write latency.** A grant in cycle N produces `WriteReg`, `WriteData` and `RegWriteActive` in cycle N+1, held for exactly one cycle.
- **Idle.** With no grant in cycle N, `RegWriteActive`=0 in cycle N+1. `WriteReg` and `WriteData` hold their last values.
- **Throughput.** One write per cycle; back-to-back grants are allowed.
- **Steady contention.** With both ports continuously valid, grants alternate A, B, A, B…
- **Ready when idle.** Ready may be high while the corresponding Valid is low; this has no effect.
- **Reset values.** All outputs are 0. `ReadyA`/`ReadyB` follow their Valid inputs and are therefore 0 while both Valids are 0.

## Configuration

- **Macro `WB_FORWARD_EN` defined:**
  - The forwarding ports exist.
  - `ReadDataX` = `WriteData` when `RegWriteActive`=1 and `WriteReg`==`ReadRegisterX`; otherwise `ReadDataX` = `RfDataX`.
  - Combinational path, zero latency.
  - Register 0 is never forwarded; this is guaranteed by the `RegWriteActive` gating.
- **Macro not defined:**
  - The forwarding ports are absent.
  - No bypass logic is instantiated.

## Structure

- **Package `mips_pkg`:**
  - `reg_idx_t` (ADDR_W bits)
  - `word_t` (DATA_W bits)
  - constant `REG_ZERO` = 0
  - localparam `NUM_WB_PORTS` = 2
- **Sub-module `rr_arbiter2`:** 2-input round-robin arbiter holding `PrioB`. Outputs a one-hot grant.
- **Top level:** contains the output register, the counters and the forwarding mux.

## Test plan

- **Single port:** reset; `ValidA`=1, `RegA`=5, `DataA`=0x1234 for one cycle → `ReadyA`=1; next cycle `WriteReg`=5, `WriteData`=0x1234, `RegWriteActive`=1.
- **Contention:** `ValidA` and `ValidB` held high for 4 cycles with RegA=3, RegB=4 → grants A, B, A, B; `ConflictCntA`=2 and `ConflictCntB`=2.
- **Same register:** both ports target register 7 (A=0xAA, B=0xBB) → two consecutive writes to 7, A first then B; final register value 0xBB.
- **Register 0:** `ValidB`=1, `RegB`=0 → `ReadyB`=1; next cycle `RegWriteActive`=0.
- **Reset mid-write:** grant in cycle N; `rst_n` low in cycle N+1 before the edge → `RegWriteActive` drops to 0 asynchronously; `PrioB`=0 afterwards; both counters read 0.
- **Forwarding (WB_FORWARD_EN):** write pending to register 9 with data 0x55; `ReadRegister1`=9, `RfData1`=0x11 → `ReadData1`=0x55; `ReadRegister2`=8 → `ReadData2`=`RfData2`.
